// File: rtl/position_one_hot_sequencer.sv
// Binary LED position (0..N_POS-1) shown as a one-hot red LED, binary green LEDs and two
// decimal digits. Position is set from buttons/switches or stepped automatically in sweep mode.
module position_one_hot_sequencer #(
  parameter int SWEEP_TICKS = 50_000_000,
  parameter int N_POS       = 18
) (
  input  logic                  CLOCK_50_I,
  input  logic                  RESET_I,
  input  logic [3:0]            PUSH_BUTTON_N_I,
  input  logic [17:0]           SWITCH_I,
  output logic [N_POS-1:0]      LED_RED_O,
  output logic [8:0]            LED_GREEN_O,
  output logic [7:0][6:0]       SEVEN_SEGMENT_N_O
);

  localparam int             CW      = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
  localparam logic [CW-1:0]  TC      = CW'(SWEEP_TICKS - 1);
  localparam logic [4:0]     POS_MAX = 5'(N_POS - 1);

  typedef enum logic {MANUAL, SWEEP} mode_e;

  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p == POS_MAX) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] d);
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    case (d)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'ha: hex7 = 7'h08;  4'hb: hex7 = 7'h03;
      4'hc: hex7 = 7'h46;  4'hd: hex7 = 7'h21;  4'he: hex7 = 7'h06;  default: hex7 = 7'h0e;
    endcase
  endfunction

  logic [3:0]    btn_meta, btn_sync, btn_prev, press_q;
  logic [4:0]    pos, pos_next;
  mode_e         mode, mode_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pos_btn;
  logic          tens;
  logic [3:0]    ones;
  logic          unused_sw_hi;

  assign unused_sw_hi = ^SWITCH_I[17:5];

  // Released level is 1, so leaving reset never fabricates a press; a button still held
  // low afterwards does produce one as the synchronizer drains to 0.
  always_ff @(posedge CLOCK_50_I) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET_I) begin
      btn_meta <= 4'hf;
      btn_sync <= 4'hf;
      btn_prev <= 4'hf;
      press_q  <= 4'h0;
      pos      <= 5'd0;
      mode     <= MANUAL;
      cnt      <= '0;
    end else begin
      btn_meta <= PUSH_BUTTON_N_I;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      press_q  <= btn_prev & ~btn_sync;
      pos      <= pos_next;
      mode     <= mode_next;
      cnt      <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pos_next  = pos;
    pos_btn   = 1'b0;
    mode_next = mode;
    cnt_next  = '0;

    // An out-of-range load still wins priority and swallows a coincident inc/dec.
    if (press_q[2]) begin
      if (SWITCH_I[4:0] <= POS_MAX) begin
        pos_next = SWITCH_I[4:0];
        pos_btn  = 1'b1;
      end
    end else if (press_q[0]) begin
      pos_next = wrap_inc(pos);
      pos_btn  = 1'b1;
    end else if (press_q[1]) begin
      pos_next = (pos == 5'd0) ? POS_MAX : pos - 5'd1;
      pos_btn  = 1'b1;
    end

    if (mode == SWEEP && cnt == TC && !pos_btn)
      pos_next = wrap_inc(pos);

    if (press_q[3])
      mode_next = (mode == MANUAL) ? SWEEP : MANUAL;

    // Counter restarts on entry, on wrap, on a button move, and idles at 0 in MANUAL.
    if (mode == SWEEP && mode_next == SWEEP && !pos_btn && cnt != TC)
      cnt_next = cnt + CW'(1);
  end

  assign tens = (pos >= 5'd10);
  assign ones = 4'(tens ? pos - 5'd10 : pos);

  assign LED_RED_O   = {{(N_POS-1){1'b0}}, 1'b1} << pos;
  assign LED_GREEN_O = {3'b000, mode == SWEEP, pos};

  always_comb begin
    SEVEN_SEGMENT_N_O    = '1;
    SEVEN_SEGMENT_N_O[0] = hex7(ones);
    SEVEN_SEGMENT_N_O[1] = hex7({3'b000, tens});
  end

endmodule

// File: tb/tb_position_one_hot_sequencer.sv
// Bench for position_one_hot_sequencer: directed table, hand-timed latency/sweep sequences,
// then random buttons/switches/resets against an edge-indexed behavioural model.
module tb_position_one_hot_sequencer;

  localparam int T    = 4;
  localparam int NPOS = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       btn;
  logic [17:0]      sw;
  logic [17:0]      red;
  logic [8:0]       green;
  logic [7:0][6:0]  seg;

  position_one_hot_sequencer #(.SWEEP_TICKS(T), .N_POS(NPOS)) dut (
    .CLOCK_50_I        (clk),
    .RESET_I           (rst),
    .PUSH_BUTTON_N_I   (btn),
    .SWITCH_I          (sw),
    .LED_RED_O         (red),
    .LED_GREEN_O       (green),
    .SEVEN_SEGMENT_N_O (seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: raw button samples per edge, position, mode, and the edge index of the next sweep step.
  int         ecount = 0;
  logic [3:0] samp[4] = '{4'hf, 4'hf, 4'hf, 4'hf};
  int         mpos   = 0;
  bit         msweep = 1'b0;
  int         mnext  = 0;

  typedef struct {
    logic [3:0]  press;
    logic [17:0] sw;
    int          exp_pos;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;  4: return 7'h19;
      5: return 7'h12;  6: return 7'h02;  7: return 7'h78;  8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input int p, input bit sweep);
    logic [17:0]      er;
    logic [8:0]       eg;
    logic [7:0][6:0]  es;
    er = 18'd1 << p;
    eg = {3'b000, sweep, 5'(p)};
    es = '1;
    es[0] = seg_ref(p % 10);
    es[1] = seg_ref(p / 10);
    check({tag, " red"},   64'(red),   64'(er));
    check({tag, " green"}, 64'(green), 64'(eg));
    check({tag, " seg"},   64'(seg),   64'(es));
  endtask

  // A press takes effect on the edge 3 after the first edge that samples the button low.
  task automatic model_edge();
    logic [3:0] pr;
    bit         chg;
    int         np;
    if (rst) begin
      mpos   = 0;
      msweep = 1'b0;
      for (int i = 0; i < 4; i++) samp[i] = 4'hf;
      return;
    end
    pr  = samp[3] & ~samp[2];
    chg = 1'b0;
    np  = mpos;
    if (pr[2]) begin
      if (int'(sw[4:0]) < NPOS) begin np = int'(sw[4:0]); chg = 1'b1; end
    end else if (pr[0]) begin
      np = (mpos + 1) % NPOS; chg = 1'b1;
    end else if (pr[1]) begin
      np = (mpos + NPOS - 1) % NPOS; chg = 1'b1;
    end
    if (msweep) begin
      if (chg) mnext = ecount + T;
      else if (ecount == mnext) begin
        np    = (mpos + 1) % NPOS;
        mnext = ecount + T;
      end
    end
    if (pr[3]) begin
      msweep = !msweep;
      if (msweep) mnext = ecount + T;
    end
    mpos = np;
    samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_edge();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    btn = ~mask;
    repeat (hold) tick();
    btn = 4'hf;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 18'd0,                  1};
    vecs[1]  = '{4'b0010, 18'd0,                  0};
    vecs[2]  = '{4'b0010, 18'd0,                  17};
    vecs[3]  = '{4'b0001, 18'd0,                  0};
    vecs[4]  = '{4'b0100, 18'd12,                 12};
    vecs[5]  = '{4'b0100, 18'd20,                 12};
    vecs[6]  = '{4'b0101, 18'd25,                 12};
    vecs[7]  = '{4'b0011, 18'd0,                  13};
    vecs[8]  = '{4'b0111, 18'd3,                  3};
    vecs[9]  = '{4'b0100, 18'd10,                 10};
    vecs[10] = '{4'b0010, 18'd0,                  9};
    vecs[11] = '{4'b0100, {13'h1fff, 5'd17},      17};
    vecs[12] = '{4'b0001, 18'd0,                  0};

    rst = 1'b1; btn = 4'hf; sw = '0;
    tick(); tick();
    rst = 1'b0;

    check_outputs("reset", 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle red", 64'(red), 64'(18'h00001));
    end

    for (int i = 0; i < 13; i++) begin
      sw = vecs[i].sw;
      press(vecs[i].press, 6);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_pos, 1'b0);
    end

    // Increment wrap from 17 with exact latency and a long hold giving one step.
    sw = 18'd17;
    press(4'b0100, 6);
    btn = 4'b1110;
    tick(); tick(); tick();
    check_outputs("inc lat N+2", 17, 1'b0);
    tick();
    check_outputs("inc lat N+3", 0, 1'b0);
    repeat (17) tick();
    check_outputs("inc held", 0, 1'b0);
    btn = 4'hf;
    repeat (4) tick();
    check_outputs("inc release", 0, 1'b0);

    // Sweep from 16: entry edge E, steps at E+4, E+8, E+12.
    sw = 18'd16;
    press(4'b0100, 6);
    btn = 4'b0111;
    tick(); tick(); tick();
    check_outputs("tog N+2", 16, 1'b0);
    tick();
    check_outputs("sweep entry", 16, 1'b1);
    btn = 4'hf;
    repeat (3) tick();
    check_outputs("sweep E+3", 16, 1'b1);
    tick();
    check_outputs("sweep E+4", 17, 1'b1);
    repeat (3) tick();
    check_outputs("sweep E+7", 17, 1'b1);
    tick();
    check_outputs("sweep E+8", 0, 1'b1);
    repeat (4) tick();
    check_outputs("sweep E+12", 1, 1'b1);

    // Increment lands on the terminal-count edge E+16: one +1, counter restarts.
    btn = 4'b1110;
    tick(); tick(); tick();
    check_outputs("coinc E+15", 1, 1'b1);
    tick();
    check_outputs("coinc E+16", 2, 1'b1);
    btn = 4'hf;
    repeat (3) tick();
    check_outputs("coinc E+19", 2, 1'b1);
    tick();
    check_outputs("coinc E+20", 3, 1'b1);

    // Reset mid-sweep with increment held through it; the held button presses after release.
    rst = 1'b1; btn = 4'b1110;
    tick();
    check_outputs("mid reset", 0, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_outputs("held thru reset N+2", 0, 1'b0);
    tick();
    check_outputs("held thru reset N+3", 1, 1'b0);
    btn = 4'hf;
    repeat (4) tick();
    check_outputs("model sync", mpos, msweep);

    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      sw = 18'($urandom);
      if ($urandom_range(0, 3) != 0) sw[4:0] = 5'($urandom_range(0, 17));
      rst = ($urandom_range(0, 199) == 0);
      tick();
      check_outputs("rand", mpos, msweep);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
